// File: rtl/pipelined_wallace_multiplier_if.sv
// Bundle of the operand and result handshake signals of pipelined_wallace_multiplier.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both 1. The producer holds its payload stable while valid is high. The
// multiplier's ready may depend combinationally on out_ready. A result stays
// put, with out_valid high, until the consumer takes it.
//
// Ports / modports:
//   master - traffic source and result sink: drives in_valid, a, b,
//            signed_mode and out_ready; observes in_ready, out_valid and product.
//   slave  - the multiplier: observes the operand side; drives in_ready,
//            out_valid and product.
// WIDTH must match the WIDTH of the multiplier this bundle is connected to.
interface pipelined_wallace_multiplier_if #(
    parameter int WIDTH = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               signed_mode;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] product;

    modport master (
        output in_valid, a, b, signed_mode, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, a, b, signed_mode, out_ready,
        output in_ready, out_valid, product
    );
endinterface

// File: rtl/pipelined_wallace_multiplier.sv
// Pipelined WIDTH x WIDTH multiplier. The signed_mode input selects unsigned or
// two's-complement operands. The result is the exact 2*WIDTH-bit product.
//
// Datapath: WIDTH partial-product rows. In signed mode these use the
// Baugh-Wooley form. A Wallace tree of 3:2 compressors reduces them to two
// rows. A carry-propagate adder finishes the sum. The tree levels and the final
// adder are split as evenly as possible over STAGES register stages. A result
// appears STAGES cycles after acceptance when the pipeline is not stalled.
//
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset; clears every stage, product and out_valid
//   bus - pipelined_wallace_multiplier_if.slave
//         (in_valid/in_ready/a/b/signed_mode in, out_valid/out_ready/product out)
//
// Flow control: the whole pipeline advances together unless a finished result
// is waiting and out_ready is low. Bubbles never block new data.
module pipelined_wallace_multiplier #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 3
) (
    input logic                          clk,
    input logic                          rst,
    pipelined_wallace_multiplier_if.slave bus
);
    localparam int PW = 2 * WIDTH;

    typedef logic [WIDTH-1:0][PW-1:0] rows_t;

    // Rows left after one compressor level: each group of three becomes two,
    // and leftover rows pass through.
    function automatic int next_count(input int n);
        return 2 * (n / 3) + (n % 3);
    endfunction

    function automatic int num_levels(input int n);
        int c;
        int l;
        c = n;
        l = 0;
        while (c > 2) begin
            c = next_count(c);
            l++;
        end
        return l;
    endfunction

    // Work units: one per tree level, plus one for the final adder.
    localparam int NLEV  = num_levels(WIDTH);
    localparam int UNITS = NLEV + 1;

    // Number of live rows entering work unit u.
    function automatic int rows_at(input int u);
        int c;
        c = WIDTH;
        for (int i = 0; i < u; i++) begin
            c = (i < NLEV) ? next_count(c) : 1;
        end
        return c;
    endfunction

    logic  advance;
    rows_t pp;

    // Stall only when a finished result is waiting and nobody takes it.
    assign advance      = ~(bus.out_valid & ~bus.out_ready);
    assign bus.in_ready = advance;

    // Partial products. In signed mode, the bits that pair one operand's sign
    // bit with a non-sign bit of the other are inverted. Two constant ones,
    // at weights WIDTH and 2*WIDTH-1, complete the modified Baugh-Wooley sum.
    // Both constants sit in bit positions that their rows leave empty, so the
    // row count stays at WIDTH.
    always_comb begin
        pp = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                pp[i][i+j] = (bus.a[j] & bus.b[i])
                           ^ (bus.signed_mode & ((i == WIDTH - 1) ^ (j == WIDTH - 1)));
            end
        end
        if (bus.signed_mode) begin
            pp[0][WIDTH]        = 1'b1;
            pp[WIDTH-1][PW-1]   = 1'b1;
        end
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int LO = (s * UNITS) / STAGES;
        localparam int HI = ((s + 1) * UNITS) / STAGES;

        logic                               v;
        logic                               sm;
        rows_t                              q;
        logic                               v_in;
        logic                               sm_in;
        logic [HI-LO:0][WIDTH-1:0][PW-1:0]  lvl;
        logic                               unused_lvl;

        if (s == 0) begin : g_in
            assign lvl[0] = pp;
            assign v_in   = bus.in_valid;
            assign sm_in  = bus.signed_mode;
        end else begin : g_in
            assign lvl[0] = g_stage[s-1].q;
            assign v_in   = g_stage[s-1].v;
            assign sm_in  = g_stage[s-1].sm;
        end

        for (genvar u = LO; u < HI; u++) begin : g_unit
            localparam int J = u - LO;
            localparam int N = rows_at(u);
            localparam int M = next_count(N);

            if (u < NLEV) begin : g_csa
                // Bitwise full adders across three rows. Where a row has no
                // bit, synthesis folds the cell into a half adder or a wire.
                for (genvar g = 0; g < N / 3; g++) begin : g_fa
                    assign lvl[J+1][2*g] = lvl[J][3*g] ^ lvl[J][3*g+1] ^ lvl[J][3*g+2];
                    assign lvl[J+1][2*g+1] = ((lvl[J][3*g]   & lvl[J][3*g+1])
                                            | (lvl[J][3*g]   & lvl[J][3*g+2])
                                            | (lvl[J][3*g+1] & lvl[J][3*g+2])) << 1;
                end
                for (genvar r = 0; r < N % 3; r++) begin : g_pass
                    assign lvl[J+1][2*(N/3)+r] = lvl[J][3*(N/3)+r];
                end
                if (M < WIDTH) begin : g_zero
                    assign lvl[J+1][WIDTH-1:M] = '0;
                end
            end else begin : g_cpa
                // Carries beyond 2*WIDTH bits are dropped; the exact product
                // always fits, so nothing is lost.
                assign lvl[J+1][0]         = lvl[J][0] + lvl[J][1];
                assign lvl[J+1][WIDTH-1:1] = '0;
            end
        end

        // Rows that are already retired or zero go nowhere.
        assign unused_lvl = ^lvl;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v  <= 1'b0;
                sm <= 1'b0;
                q  <= '0;
            end else if (advance) begin
                v  <= v_in;
                sm <= sm_in;
                q  <= lvl[HI-LO];
            end
        end
    end

    assign bus.out_valid = g_stage[STAGES-1].v;
    assign bus.product   = g_stage[STAGES-1].q[0];

    // The mode bit and the zeroed rows of the last stage feed nothing.
    logic unused_tail;
    assign unused_tail = ^{g_stage[STAGES-1].sm, g_stage[STAGES-1].q[WIDTH-1:1]};
endmodule

// File: tb/tb_pipelined_wallace_multiplier.sv
// Self-checking bench for pipelined_wallace_multiplier.
// Directed tables run on WIDTH=4 and WIDTH=8 instances, both with STAGES=3.
// A cycle table covers backpressure, and a hand sequence covers reset in
// mid-flight. Random traffic runs on the (4,1), (8,3) and (16,6) instances.
module tb_pipelined_wallace_multiplier;
    localparam int N4  = 6;
    localparam int N8  = 13;
    localparam int NBP = 13;
    localparam int NSW = 3400;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        sm;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        logic        iv;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        sm;
        logic        ordy;
        logic        exp_ir;
        logic        exp_ov;
        logic [15:0] exp_p;
    } cyc_t;

    logic clk = 1'b0;
    logic rst_d;
    logic rst_sw;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference product, reduced to 2*w bits.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic sm, input int w);
        logic [63:0] mask;
        logic [63:0] xa;
        logic [63:0] xb;
        mask = (64'd1 << w) - 64'd1;
        xa = {32'd0, a} & mask;
        xb = {32'd0, b} & mask;
        if (sm && xa[w-1]) xa = xa | ~mask;
        if (sm && xb[w-1]) xb = xb | ~mask;
        return (xa * xb) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    pipelined_wallace_multiplier_if #(.WIDTH(4)) if4 ();
    pipelined_wallace_multiplier_if #(.WIDTH(8)) if8 ();

    pipelined_wallace_multiplier #(.WIDTH(4), .STAGES(3)) dut4 (
        .clk (clk),
        .rst (rst_d),
        .bus (if4.slave)
    );

    pipelined_wallace_multiplier #(.WIDTH(8), .STAGES(3)) dut8 (
        .clk (clk),
        .rst (rst_d),
        .bus (if8.slave)
    );

    initial begin
        rst_sw = 1'b1;
        repeat (3) @(negedge clk);
        rst_sw = 1'b0;
    end

    for (genvar g = 0; g < 3; g++) begin : g_sweep
        localparam int W = (g == 0) ? 4 : (g == 1) ? 8 : 16;
        localparam int S = (g == 0) ? 1 : (g == 1) ? 3 : 6;

        pipelined_wallace_multiplier_if #(.WIDTH(W)) sif ();

        pipelined_wallace_multiplier #(.WIDTH(W), .STAGES(S)) dut (
            .clk (clk),
            .rst (rst_sw),
            .bus (sif.slave)
        );

        logic [2*W-1:0] exp_q[$];
        logic           done = 1'b0;

        initial begin : drive
            int             sent;
            int             got;
            int             cyc;
            logic           stalled;
            logic [2*W-1:0] held;
            logic [63:0]    r;
            sent    = 0;
            got     = 0;
            cyc     = 0;
            stalled = 1'b0;
            held    = '0;
            sif.in_valid    = 1'b0;
            sif.a           = '0;
            sif.b           = '0;
            sif.signed_mode = 1'b0;
            sif.out_ready   = 1'b0;
            wait (rst_sw === 1'b0);
            while (got < NSW && cyc < 20 * NSW) begin
                @(negedge clk);
                cyc++;
                sif.in_valid    = (sent < NSW) && ($urandom_range(0, 3) != 0);
                sif.a           = W'($urandom);
                sif.b           = W'($urandom);
                sif.signed_mode = 1'($urandom_range(0, 1));
                sif.out_ready   = ($urandom_range(0, 3) != 0);
                #1;
                if (stalled) begin
                    chk($sformatf("sw%0d_hold_v", W), sif.out_valid, 1'b1);
                    chk($sformatf("sw%0d_hold_p", W), sif.product, held);
                end
                if (sif.out_valid && sif.out_ready) begin
                    chk($sformatf("sw%0d_expected_any", W), exp_q.size() > 0, 1'b1);
                    if (exp_q.size() > 0) begin
                        chk($sformatf("sw%0d_p[%0d]", W, got), sif.product, exp_q.pop_front());
                    end
                    got++;
                end
                if (sif.in_valid && sif.in_ready) begin
                    r = ref_mul(32'(sif.a), 32'(sif.b), sif.signed_mode, W);
                    exp_q.push_back(r[2*W-1:0]);
                    sent++;
                end
                stalled = sif.out_valid && !sif.out_ready;
                held    = sif.product;
            end
            chk($sformatf("sw%0d_count", W), got, NSW);
            chk($sformatf("sw%0d_left", W), exp_q.size(), 0);
            done = 1'b1;
        end
    end

    initial begin : main
        vec_t v4 [N4];
        vec_t v8 [N8];
        cyc_t bp [NBP];

        v4 = '{
            '{8'h0A, 8'h03, 1'b0, 16'h001E},
            '{8'h0A, 8'h03, 1'b1, 16'h00EE},
            '{8'h0F, 8'h0F, 1'b0, 16'h00E1},
            '{8'h0F, 8'h0F, 1'b1, 16'h0001},
            '{8'h08, 8'h08, 1'b1, 16'h0040},
            '{8'h07, 8'h08, 1'b1, 16'h00C8}
        };
        v8 = '{
            '{8'hFF, 8'hFF, 1'b0, 16'hFE01},
            '{8'h80, 8'h80, 1'b1, 16'h4000},
            '{8'h80, 8'h7F, 1'b1, 16'hC080},
            '{8'h00, 8'hC8, 1'b0, 16'h0000},
            '{8'h07, 8'h09, 1'b0, 16'h003F},
            '{8'hFF, 8'hFF, 1'b1, 16'h0001},
            '{8'h80, 8'h80, 1'b0, 16'h4000},
            '{8'hFF, 8'h01, 1'b1, 16'hFFFF},
            '{8'h64, 8'h03, 1'b0, 16'h012C},
            '{8'h7F, 8'h7F, 1'b1, 16'h3F01},
            '{8'hF0, 8'h10, 1'b1, 16'hFF00},
            '{8'hC8, 8'hC8, 1'b0, 16'h9C40},
            '{8'h9C, 8'h05, 1'b1, 16'hFE0C}
        };
        // One row per cycle: inputs to drive, in_ready expected after driving,
        // and the output expected at the start of the cycle.
        bp = '{
            '{1'b1, 8'h03, 8'h05, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000},
            '{1'b1, 8'hFE, 8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000},
            '{1'b1, 8'hC8, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000},
            '{1'b1, 8'h81, 8'h81, 1'b1, 1'b0, 1'b0, 1'b1, 16'h000F},
            '{1'b1, 8'h81, 8'h81, 1'b1, 1'b0, 1'b0, 1'b1, 16'h000F},
            '{1'b1, 8'h81, 8'h81, 1'b1, 1'b0, 1'b0, 1'b1, 16'h000F},
            '{1'b1, 8'h81, 8'h81, 1'b1, 1'b0, 1'b0, 1'b1, 16'h000F},
            '{1'b1, 8'h81, 8'h81, 1'b1, 1'b1, 1'b1, 1'b1, 16'h000F},
            '{1'b1, 8'h0C, 8'h0C, 1'b0, 1'b1, 1'b1, 1'b1, 16'hFFF2},
            '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0190},
            '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 16'h3F01},
            '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0090},
            '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000}
        };

        // Clock/reset
        rst_d = 1'b1;
        if4.in_valid = 1'b0; if4.a = '0; if4.b = '0; if4.signed_mode = 1'b0; if4.out_ready = 1'b1;
        if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.signed_mode = 1'b0; if8.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst4_out_valid", if4.out_valid, 1'b0);
        chk("rst4_product", if4.product, 8'h00);
        chk("rst4_in_ready", if4.in_ready, 1'b1);
        chk("rst8_out_valid", if8.out_valid, 1'b0);
        chk("rst8_product", if8.product, 16'h0000);
        chk("rst8_in_ready", if8.in_ready, 1'b1);
        rst_d = 1'b0;

        // WIDTH=4: each vector is due exactly 3 cycles after it is driven.
        for (int k = 0; k < N4 + 4; k++) begin
            @(negedge clk);
            if (k >= 3 && k < N4 + 3) begin
                chk($sformatf("v4_out_valid[%0d]", k - 3), if4.out_valid, 1'b1);
                chk($sformatf("v4_product[%0d]", k - 3), if4.product, v4[k-3].exp[7:0]);
            end else begin
                chk($sformatf("v4_idle[%0d]", k), if4.out_valid, 1'b0);
            end
            if (k < N4) begin
                if4.in_valid = 1'b1; if4.a = v4[k].a[3:0]; if4.b = v4[k].b[3:0];
                if4.signed_mode = v4[k].sm;
            end else begin
                if4.in_valid = 1'b0;
            end
        end

        // WIDTH=8: back-to-back, one result per cycle, in order.
        for (int k = 0; k < N8 + 4; k++) begin
            @(negedge clk);
            if (k >= 3 && k < N8 + 3) begin
                chk($sformatf("v8_out_valid[%0d]", k - 3), if8.out_valid, 1'b1);
                chk($sformatf("v8_product[%0d]", k - 3), if8.product, v8[k-3].exp);
            end else begin
                chk($sformatf("v8_idle[%0d]", k), if8.out_valid, 1'b0);
            end
            if (k < N8) begin
                if8.in_valid = 1'b1; if8.a = v8[k].a; if8.b = v8[k].b; if8.signed_mode = v8[k].sm;
            end else begin
                if8.in_valid = 1'b0;
            end
        end

        // Backpressure: five transactions, output held for four cycles.
        for (int k = 0; k < NBP; k++) begin
            @(negedge clk);
            chk($sformatf("bp_out_valid[%0d]", k), if8.out_valid, bp[k].exp_ov);
            if (bp[k].exp_ov) chk($sformatf("bp_product[%0d]", k), if8.product, bp[k].exp_p);
            if8.in_valid = bp[k].iv; if8.a = bp[k].a; if8.b = bp[k].b;
            if8.signed_mode = bp[k].sm; if8.out_ready = bp[k].ordy;
            #1;
            chk($sformatf("bp_in_ready[%0d]", k), if8.in_ready, bp[k].exp_ir);
        end

        // Reset in mid-flight: three accepted, then rst. Nothing old may emerge.
        if8.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if8.in_valid = 1'b1; if8.a = 8'(10 * (k + 1)); if8.b = 8'd3; if8.signed_mode = 1'b0;
        end
        @(posedge clk);
        #1;
        rst_d = 1'b1;
        if8.in_valid = 1'b0;
        #1;
        chk("midrst_out_valid", if8.out_valid, 1'b0);
        chk("midrst_product", if8.product, 16'h0000);
        chk("midrst_in_ready", if8.in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        rst_d = 1'b0;
        if8.in_valid = 1'b1; if8.a = 8'd7; if8.b = 8'd9; if8.signed_mode = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if8.in_valid = 1'b0;
            if (k == 3) begin
                chk("postrst_out_valid", if8.out_valid, 1'b1);
                chk("postrst_product", if8.product, 16'h003F);
            end else begin
                chk($sformatf("postrst_idle[%0d]", k), if8.out_valid, 1'b0);
            end
        end

        wait (g_sweep[0].done && g_sweep[1].done && g_sweep[2].done);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
